// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding, defaults and PC helpers for the fetch sequencer
package fetch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_e;

  localparam int          DEF_RD_WAIT  = 2;
  localparam int          DEF_DEPTH    = 2;
  localparam logic [63:0] DEF_RESET_PC = 64'h0;
  localparam logic [63:0] PC_INC       = 64'd4;

  function automatic logic [63:0] align_pc(input logic [63:0] pc);
    return {pc[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry {pc,inst} buffer with flush; head is the oldest entry
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          resetl_i,
  input  logic          push_i,
  input  logic [95:0]   push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [CW-1:0] count_o,
  output logic [95:0]   head_o
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_IX = AW'(DEPTH - 1);

  logic [95:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q;
  logic          push_ok, pop_ok;

  assign pop_ok  = pop_i && (count_q != '0) && !flush_i;
  assign push_ok = push_i && !flush_i && ((count_q != DEPTH_C) || pop_ok);

  function automatic logic [AW-1:0] next_ix(input logic [AW-1:0] ix);
    return (ix == LAST_IX) ? '0 : ix + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (!resetl_i || flush_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_q <= next_ix(wr_q);
      if (pop_ok)  rd_q <= next_ix(rd_q);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= push_data_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fixed-latency instruction fetcher feeding a small ready/valid buffer
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int          RD_WAIT  = DEF_RD_WAIT,
  parameter logic [63:0] RESET_PC = DEF_RESET_PC,
  parameter int          DEPTH    = DEF_DEPTH
) (
  input  logic        CLK,
  input  logic        resetl,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  input  logic        halt,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [63:0] inst_pc,
  output logic        busy
);

  localparam int            CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(DEPTH);
  localparam logic [3:0]    LAST_CNT = 4'(RD_WAIT - 1);

  fetch_state_e  state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count;
  logic [95:0]   head;
  logic          push, pop, flush, fetch_done;
  logic [CW:0]   post_count;

  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready;
  assign fetch_done = (state_q == WAIT) && (cnt_q == LAST_CNT);
  // Occupancy after this edge's push and pop decides whether to keep streaming.
  assign post_count = {1'b0, count} + (CW + 1)'(fetch_done) - (CW + 1)'(pop);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    flush      = 1'b0;
    if (redirect) begin
      flush      = 1'b1;
      fetch_pc_d = align_pc(redirect_pc);
      cnt_d      = '0;
      state_d    = halt ? IDLE : WAIT;
    end else begin
      case (state_q)
        IDLE: begin
          if (!halt && (count < DEPTH_C)) begin
            state_d = WAIT;
            cnt_d   = '0;
          end
        end
        WAIT: begin
          if (fetch_done) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + PC_INC;
            cnt_d      = '0;
            state_d    = (!halt && (post_count < DEPTH_W)) ? WAIT : IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!resetl) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH),
    .CW   (CW)
  ) u_fifo (
    .clk_i      (CLK),
    .resetl_i   (resetl),
    .push_i     (push),
    .push_data_i({fetch_pc_q, imem_data}),
    .pop_i      (pop),
    .flush_i    (flush),
    .count_o    (count),
    .head_o     (head)
  );

  assign imem_addr = fetch_pc_q;
  assign busy      = (state_q == WAIT);
  assign inst_pc   = head[95:32];
  assign inst_out  = head[31:0];

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed and randomized checks of fetch_sequencer against a queue model
module tb_fetch_sequencer;

  localparam int          RD_WAIT  = 2;
  localparam int          DEPTH    = 2;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        CLK = 1'b0;
  logic        resetl = 1'b0;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        halt = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_out;
  logic [63:0] inst_pc;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  fetch_sequencer #(.RD_WAIT(RD_WAIT), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .resetl(resetl), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out),
    .inst_pc(inst_pc), .busy(busy)
  );

  function automatic logic [31:0] rom_word(input logic [63:0] a);
    if (a[63:6] != 58'h0) return a[33:2] ^ 32'h5A5A_1234;
    case (a[5:2])
      4'd0:    return 32'hF84003E9;
      4'd1:    return 32'hF84083EA;
      4'd2:    return 32'hF84103EB;
      4'd8:    return 32'h8B0901AD;
      4'd9:    return 32'hCB09018C;
      4'd11:   return 32'hF80203ED;
      default: return {28'hD15EA5E, a[5:2]};
    endcase
  endfunction

  assign imem_data = rom_word(imem_addr);

  // Reference: a fetch is either in flight (with elapsed cycles) or not; delivered words sit in a queue.
  logic        m_fetching = 1'b0;
  int          m_el = 0;
  logic [63:0] m_pc = RESET_PC;
  logic [95:0] m_q[$];

  task automatic model_update;
    int   sz0;
    logic pop_now, done;
    sz0     = m_q.size();
    pop_now = (sz0 != 0) && inst_ready;
    done    = m_fetching && (m_el == RD_WAIT - 1);
    if (!resetl) begin
      m_fetching = 1'b0; m_el = 0; m_q.delete(); m_pc = RESET_PC;
    end else if (redirect) begin
      m_q.delete(); m_pc = {redirect_pc[63:2], 2'b00}; m_fetching = !halt; m_el = 0;
    end else begin
      if (pop_now) void'(m_q.pop_front());
      if (done) begin
        m_q.push_back({m_pc, rom_word(m_pc)});
        m_pc = m_pc + 64'd4;
        m_el = 0;
        m_fetching = !halt && (m_q.size() < DEPTH);
      end else if (m_fetching) begin
        m_el++;
      end else if (!halt && sz0 < DEPTH) begin
        m_fetching = 1'b1; m_el = 0;
      end
    end
  endtask

  task automatic step;
    model_update();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset;
    resetl = 1'b0; redirect = 1'b0; halt = 1'b0; inst_ready = 1'b0;
    step(); step();
    resetl = 1'b1;
  endtask

  task automatic test_reset;
    resetl = 1'b0; redirect = 1'b1; redirect_pc = 64'h40; halt = 1'b0; inst_ready = 1'b1;
    step();
    redirect = 1'b0;
    total++; if (imem_addr !== RESET_PC) begin bad++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, RESET_PC); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_stream;
    do_reset();
    inst_ready = 1'b1;
    step();
    total++; if (busy !== 1'b1 || imem_addr !== 64'h0) begin bad++; $display("FAIL stream_start busy=%b addr=%h exp busy=1 addr=0", busy, imem_addr); end
    step();
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL stream_early_valid got=%b exp=0", inst_valid); end
    step();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 64'h0 || inst_out !== 32'hF84003E9) begin bad++; $display("FAIL stream_first got v=%b pc=%h w=%h exp v=1 pc=0 w=F84003E9", inst_valid, inst_pc, inst_out); end
    total++; if (imem_addr !== 64'h4) begin bad++; $display("FAIL stream_addr4 got=%h exp=4", imem_addr); end
    step();
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL stream_popped got=%b exp=0", inst_valid); end
    step();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 64'h4 || inst_out !== 32'hF84083EA) begin bad++; $display("FAIL stream_second got v=%b pc=%h w=%h exp v=1 pc=4 w=F84083EA", inst_valid, inst_pc, inst_out); end
    total++; if (imem_addr !== 64'h8) begin bad++; $display("FAIL stream_addr8 got=%h exp=8", imem_addr); end
  endtask

  task automatic test_backpressure;
    do_reset();
    repeat (5) step();
    total++; if (busy !== 1'b0 || imem_addr !== 64'h8) begin bad++; $display("FAIL bp_full busy=%b addr=%h exp busy=0 addr=8", busy, imem_addr); end
    total++; if (inst_valid !== 1'b1 || inst_pc !== 64'h0 || inst_out !== 32'hF84003E9) begin bad++; $display("FAIL bp_head0 got v=%b pc=%h w=%h exp v=1 pc=0 w=F84003E9", inst_valid, inst_pc, inst_out); end
    repeat (3) step();
    total++; if (busy !== 1'b0 || imem_addr !== 64'h8) begin bad++; $display("FAIL bp_hold busy=%b addr=%h exp busy=0 addr=8", busy, imem_addr); end
    inst_ready = 1'b1;
    step();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 64'h4 || inst_out !== 32'hF84083EA) begin bad++; $display("FAIL bp_head1 got v=%b pc=%h w=%h exp v=1 pc=4 w=F84083EA", inst_valid, inst_pc, inst_out); end
    step();
    total++; if (busy !== 1'b1 || imem_addr !== 64'h8) begin bad++; $display("FAIL bp_resume busy=%b addr=%h exp busy=1 addr=8", busy, imem_addr); end
  endtask

  task automatic test_redirect;
    int n;
    do_reset();
    repeat (4) step();
    redirect = 1'b1; redirect_pc = 64'h20;
    step();
    redirect = 1'b0;
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL redir_flush got=%b exp=0", inst_valid); end
    total++; if (busy !== 1'b1 || imem_addr !== 64'h20) begin bad++; $display("FAIL redir_target busy=%b addr=%h exp busy=1 addr=20", busy, imem_addr); end
    inst_ready = 1'b1;
    n = 0; while (!inst_valid && n < 10) begin step(); n++; end
    total++; if (inst_valid !== 1'b1 || inst_pc !== 64'h20 || inst_out !== 32'h8B0901AD) begin bad++; $display("FAIL redir_first got v=%b pc=%h w=%h exp v=1 pc=20 w=8B0901AD", inst_valid, inst_pc, inst_out); end
    step();
    n = 0; while (!inst_valid && n < 10) begin step(); n++; end
    total++; if (inst_valid !== 1'b1 || inst_pc !== 64'h24 || inst_out !== 32'hCB09018C) begin bad++; $display("FAIL redir_second got v=%b pc=%h w=%h exp v=1 pc=24 w=CB09018C", inst_valid, inst_pc, inst_out); end
  endtask

  task automatic test_misaligned;
    int n;
    do_reset();
    inst_ready = 1'b1;
    step();
    redirect = 1'b1; redirect_pc = 64'h2E;
    step();
    redirect = 1'b0;
    total++; if (imem_addr !== 64'h2C) begin bad++; $display("FAIL misalign_addr got=%h exp=2c", imem_addr); end
    n = 0; while (!inst_valid && n < 10) begin step(); n++; end
    total++; if (inst_valid !== 1'b1 || inst_pc !== 64'h2C || inst_out !== 32'hF80203ED) begin bad++; $display("FAIL misalign_word got v=%b pc=%h w=%h exp v=1 pc=2c w=F80203ED", inst_valid, inst_pc, inst_out); end
  endtask

  task automatic test_reset_midfetch;
    do_reset();
    redirect = 1'b1; redirect_pc = 64'h10;
    step();
    redirect = 1'b0;
    step();
    total++; if (busy !== 1'b1 || imem_addr !== 64'h10) begin bad++; $display("FAIL rstmid_pre busy=%b addr=%h exp busy=1 addr=10", busy, imem_addr); end
    resetl = 1'b0; redirect = 1'b1; redirect_pc = 64'h30;
    step();
    redirect = 1'b0;
    total++; if (imem_addr !== 64'h0 || inst_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_post addr=%h v=%b busy=%b exp addr=0 v=0 busy=0", imem_addr, inst_valid, busy); end
    resetl = 1'b1;
    repeat (3) step();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 64'h0) begin bad++; $display("FAIL rstmid_restart got v=%b pc=%h exp v=1 pc=0", inst_valid, inst_pc); end
  endtask

  task automatic test_halt;
    do_reset();
    redirect = 1'b1; redirect_pc = 64'h8;
    step();
    redirect = 1'b0; halt = 1'b1;
    step();
    total++; if (busy !== 1'b1 || imem_addr !== 64'h8) begin bad++; $display("FAIL halt_inflight busy=%b addr=%h exp busy=1 addr=8", busy, imem_addr); end
    step();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 64'h8 || inst_out !== 32'hF84103EB) begin bad++; $display("FAIL halt_push got v=%b pc=%h w=%h exp v=1 pc=8 w=F84103EB", inst_valid, inst_pc, inst_out); end
    total++; if (busy !== 1'b0 || imem_addr !== 64'hC) begin bad++; $display("FAIL halt_idle busy=%b addr=%h exp busy=0 addr=c", busy, imem_addr); end
    repeat (4) step();
    total++; if (busy !== 1'b0 || imem_addr !== 64'hC) begin bad++; $display("FAIL halt_hold busy=%b addr=%h exp busy=0 addr=c", busy, imem_addr); end
    halt = 1'b0;
    step();
    total++; if (busy !== 1'b1 || imem_addr !== 64'hC) begin bad++; $display("FAIL halt_release busy=%b addr=%h exp busy=1 addr=c", busy, imem_addr); end
  endtask

  task automatic test_random;
    logic [95:0] exp_head;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      resetl     = ($urandom_range(0, 49) != 0);
      halt       = ($urandom_range(0, 4) == 0);
      inst_ready = $urandom_range(0, 1) != 0;
      redirect   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = {62'h3FFF_FFFF_FFFF_FFFE, 2'($urandom_range(0, 3))};
      else                           redirect_pc = 64'($urandom_range(0, 63));
      step();
      total++; if (inst_valid !== (m_q.size() != 0)) begin bad++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", i, inst_valid, m_q.size() != 0); end
      total++; if (imem_addr !== m_pc) begin bad++; $display("FAIL rand_addr cyc=%0d got=%h exp=%h", i, imem_addr, m_pc); end
      total++; if (busy !== m_fetching) begin bad++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", i, busy, m_fetching); end
      if (m_q.size() != 0) begin
        exp_head = m_q[0];
        total++; if ({inst_pc, inst_out} !== exp_head) begin bad++; $display("FAIL rand_head cyc=%0d got=%h_%h exp=%h_%h", i, inst_pc, inst_out, exp_head[95:32], exp_head[31:0]); end
      end
    end
    resetl = 1'b1; redirect = 1'b0; halt = 1'b0;
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_reset_midfetch();
    test_halt();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
